// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-access initiator: FSM states, width codes, header layout.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_HEADER,
        ST_GAP,
        ST_DATA,
        ST_CS_HOLD,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        W8   = 2'b00,
        W16  = 2'b01,
        W32  = 2'b10,
        WRSV = 2'b11
    } width_t;

    localparam int HDR_W         = 16;
    localparam int HDR_RW_POS    = 15;
    localparam int HDR_WIDTH_LSB = 8;
    localparam int HDR_ADDR_LSB  = 0;
    localparam int HDR_ADDR_W    = 6;
    localparam int BITCNT_W      = 6;

    // The reserved code behaves exactly like a 32-bit access, header included.
    function automatic width_t norm_width(input logic [1:0] w);
        return (w == WRSV) ? W32 : width_t'(w);
    endfunction

    function automatic logic [BITCNT_W-1:0] width_bits(input width_t w);
        case (w)
            W8:      return 6'd8;
            W16:     return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [HDR_W-1:0] build_hdr(input logic rw, input width_t w,
                                                   input logic [HDR_ADDR_W-1:0] addr);
        logic [HDR_W-1:0] h;
        h = '0;
        h[HDR_RW_POS] = rw;
        h[HDR_WIDTH_LSB +: 2] = w;
        h[HDR_ADDR_LSB +: HDR_ADDR_W] = addr;
        return h;
    endfunction

endpackage

// File: rtl/spi_reg_initiator_if.sv
// Command/response handshake plus SPI pins of the register-access initiator.
// master = initiator side, slave = command source / SPI responder side.
interface spi_reg_initiator_if #(
    parameter int ADDR_W = 6,
    parameter int REG_W  = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [1:0]        cmd_width;
    logic [ADDR_W-1:0] cmd_addr;
    logic [REG_W-1:0]  cmd_wdata;
    logic              rsp_valid;
    logic [REG_W-1:0]  rsp_rdata;
    logic              busy;
    logic              spi_cs_n;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;

    modport master (
        input  cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso,
        output cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_width, cmd_addr, cmd_wdata, spi_miso,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, spi_cs_n, spi_clk, spi_mosi
    );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock divider: CLK_DIV clk cycles per half-period, strobes on the last cycle of each half.
// Latency: sclk follows a strobe by one clk; held in reset (phase high, sclk low) while en is low.
// Backpressure: none; the FSM gates it via en, and gate masks sclk outside bit phases.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic gate,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             last;

    // phase starts high so the chip-select setup half behaves like a virtual high phase:
    // its end is a fall strobe that launches the first bit.
    assign last     = (cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb = en && last && !phase;
    assign fall_stb = en && last && phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b1;
            sclk  <= 1'b0;
        end else if (last) begin
            cnt   <= '0;
            phase <= !phase;
            sclk  <= !phase && gate;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 register-access initiator: one command -> {16b header, [gap], 8/16/32b data} frame.
// Latency: CLK_DIV*(2*(16+gap+bits)+2)+1 clk from acceptance to rsp_valid (gap=0 for writes).
// Backpressure: cmd_ready only in IDLE; one frame in flight. Option macro: SPI_MISO_SYNC_EN.
module spi_reg_initiator
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = 6,
    parameter int REG_W    = 32,
    parameter int READ_GAP = 8
) (
    input  logic                clk,
    input  logic                rst,
    spi_reg_initiator_if.master bus
);

    state_t               state, state_nxt;
    logic [HDR_W-1:0]     hdr_sr;
    logic [REG_W-1:0]     data_sr;
    logic [BITCNT_W-1:0]  bit_cnt;
    logic [BITCNT_W-1:0]  lat_bits;
    logic                 lat_rw;
    logic                 cs_n_q;
    logic                 mosi_q;
    logic [REG_W-1:0]     rdata_q;

    logic                 rise_stb, fall_stb, sclk;
    logic                 clk_en, clk_gate;
    logic                 miso_smp, smp_stb;
    logic                 accept;
    logic                 hdr_last, gap_last, data_last;
    width_t               acc_width;
    logic [BITCNT_W-1:0]  acc_bits;

    assign acc_width = norm_width(bus.cmd_width);
    assign acc_bits  = width_bits(acc_width);
    assign accept    = (state == ST_IDLE) && bus.cmd_valid;
    assign hdr_last  = (bit_cnt == BITCNT_W'(HDR_W - 1));
    assign gap_last  = (bit_cnt == BITCNT_W'(READ_GAP - 1));
    assign data_last = (bit_cnt == lat_bits - 1'b1);

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync;

    if (CLK_DIV < 3) begin : g_div_chk
        $error("spi_reg_initiator: CLK_DIV must be >= 3 with the MISO synchronizer");
    end

    always_ff @(posedge clk) begin
        if (rst) miso_sync <= 2'b00;
        else     miso_sync <= {miso_sync[0], bus.spi_miso};
    end

    // Synchronized MISO lags two clk, so sample at the very end of the high phase.
    assign miso_smp = miso_sync[1];
    assign smp_stb  = fall_stb;
`else
    if (CLK_DIV < 2) begin : g_div_chk
        $error("spi_reg_initiator: CLK_DIV must be >= 2");
    end

    assign miso_smp = bus.spi_miso;
    assign smp_stb  = rise_stb;
`endif

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (clk_en),
        .gate     (clk_gate),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sclk     (sclk)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        clk_en        = 1'b0;
        clk_gate      = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) state_nxt = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                clk_en = 1'b1;
                if (fall_stb) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                clk_en   = 1'b1;
                clk_gate = 1'b1;
                if (fall_stb && hdr_last)
                    state_nxt = (lat_rw || READ_GAP == 0) ? ST_DATA : ST_GAP;
            end
            ST_GAP: begin
                clk_en   = 1'b1;
                clk_gate = 1'b1;
                if (fall_stb && gap_last) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                clk_en   = 1'b1;
                clk_gate = 1'b1;
                if (fall_stb && data_last) state_nxt = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                clk_en = 1'b1;
                if (rise_stb) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write data is stored MSB-aligned so the next bit is always data_sr[REG_W-1];
    // read data shifts in at the LSB from a cleared register, which zero-extends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            hdr_sr   <= '0;
            data_sr  <= '0;
            bit_cnt  <= '0;
            lat_bits <= 6'd8;
            lat_rw   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            cs_n_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_rw   <= bus.cmd_rw;
                        lat_bits <= acc_bits;
                        hdr_sr   <= build_hdr(bus.cmd_rw, acc_width, HDR_ADDR_W'(bus.cmd_addr));
                        data_sr  <= bus.cmd_rw ? (bus.cmd_wdata << (REG_W - int'(acc_bits))) : '0;
                        bit_cnt  <= '0;
                        mosi_q   <= 1'b0;
                    end
                end
                ST_CS_SETUP: begin
                    if (fall_stb) mosi_q <= hdr_sr[HDR_W-1];
                end
                ST_HEADER: begin
                    if (fall_stb) begin
                        if (hdr_last) begin
                            bit_cnt <= '0;
                            mosi_q  <= lat_rw ? data_sr[REG_W-1] : 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            hdr_sr  <= hdr_sr << 1;
                            mosi_q  <= hdr_sr[HDR_W-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (fall_stb) bit_cnt <= gap_last ? '0 : bit_cnt + 1'b1;
                end
                ST_DATA: begin
                    if (fall_stb) begin
                        if (data_last) begin
                            bit_cnt <= '0;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (lat_rw) begin
                                data_sr <= data_sr << 1;
                                mosi_q  <= data_sr[REG_W-2];
                            end
                        end
                    end
                    if (!lat_rw && smp_stb) data_sr <= {data_sr[REG_W-2:0], miso_smp};
                end
                ST_CS_HOLD: begin
                    if (rise_stb) rdata_q <= lat_rw ? '0 : data_sr;
                end
                default: ;
            endcase
        end
    end

    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_clk   = sclk;
    assign bus.spi_mosi  = mosi_q;
    assign bus.rsp_rdata = rdata_q;

endmodule
